// File: rtl/sram_rw_port_driver_if.sv
// Request/response bus between a cache/table pipeline and sram_rw_port_driver.
// Handshake: a beat transfers on a rising edge where valid && ready; valid and payload hold until taken, and ready never depends on valid.
interface sram_rw_port_driver_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 7776,
    parameter int MASK_W = 16
) ();
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [MASK_W-1:0] req_wmask;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_data;

    modport master (
        output req_valid, req_write, req_addr, req_wmask, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wmask, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_data
    );
endinterface

// File: rtl/sram_rw_port_driver.sv
// Drives a single-port masked-write SRAM macro (1-cycle read latency) from a request stream,
// zero-fills the array after reset and returns read data through a credit-limited response FIFO.
module sram_rw_port_driver #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 7776,
    parameter int MASK_W     = 16,
    parameter int RESP_DEPTH = 3,
    parameter int INIT_EN    = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    sram_rw_port_driver_if.slave  host,
    output logic                  init_done,
    output logic [ADDR_W-1:0]     sram_addr,
    output logic                  sram_en,
    output logic                  sram_wmode,
    output logic [MASK_W-1:0]     sram_wmask,
    output logic [DATA_W-1:0]     sram_wdata,
    input  logic [DATA_W-1:0]     sram_rdata,
    output logic                  o_dbg_state
);

    localparam int CNT_W = $clog2(RESP_DEPTH + 2);
    localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam logic [ADDR_W-1:0] INIT_LAST = {ADDR_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(RESP_DEPTH);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam state_t ST_AFTER_RESET = (INIT_EN != 0) ? ST_INIT : ST_RUN;

    state_t            r_state;
    state_t            w_next_state;
    logic [ADDR_W-1:0] r_init_addr;
    logic              r_init_done;
    logic              r_inflight;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  w_used;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [DATA_W-1:0] r_fifo [RESP_DEPTH];
    logic              w_req_ready;
    logic              w_init_last;
    logic              w_accept;
    logic              w_rd_issue;
    logic              w_push;
    logic              w_pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_AFTER_RESET;
        end else begin
            r_state <= w_next_state;
        end
    end

    // reset_n gates the strobes so nothing is issued or accepted while reset is held.
    always_comb begin
        w_next_state = r_state;
        w_used       = r_count + CNT_W'(r_inflight);
        w_req_ready  = 1'b0;
        w_init_last  = 1'b0;
        sram_en      = 1'b0;
        sram_wmode   = host.req_write;
        sram_addr    = host.req_addr;
        sram_wmask   = host.req_wmask;
        sram_wdata   = host.req_wdata;
        case (r_state)
            ST_INIT: begin
                w_init_last = (r_init_addr == INIT_LAST);
                if (w_init_last) begin
                    w_next_state = ST_RUN;
                end
                sram_en    = reset_n;
                sram_wmode = 1'b1;
                sram_addr  = r_init_addr;
                sram_wmask = '1;
                sram_wdata = '0;
            end
            ST_RUN: begin
                w_req_ready = reset_n && (w_used < CNT_LIMIT);
                sram_en     = host.req_valid && w_req_ready;
            end
            default: begin
                w_next_state = ST_AFTER_RESET;
            end
        endcase
    end

    assign w_accept   = (r_state == ST_RUN) && sram_en;
    assign w_rd_issue = w_accept && !host.req_write;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_init_addr <= '0;
        end else if (r_state == ST_INIT) begin
            r_init_addr <= r_init_addr + ADDR_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_init_done <= 1'b0;
        end else if (w_init_last || (r_state == ST_RUN)) begin
            r_init_done <= 1'b1;
        end
    end

    // The macro presents read data one cycle after the read; capture it then.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_rd_issue;
        end
    end

    assign w_push = r_inflight;
    assign w_pop  = (r_count != '0) && host.resp_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            if (w_push) begin
                r_wr_ptr <= ptr_next(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
        end
    end

    // Payload storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= sram_rdata;
        end
    end

    assign host.req_ready  = w_req_ready;
    assign host.resp_valid = (r_count != '0);
    assign host.resp_data  = r_fifo[r_rd_ptr];
    assign init_done       = r_init_done;
    assign o_dbg_state     = r_state;

endmodule
